// File: rtl/peak_bin_finder.sv
// peak_bin_finder: finds the strongest in-window FFT bin of each frame and reports it
//   clk_in       : system clock, rising edge
//   rst_n_in     : asynchronous active-low reset
//   mag_in       : unsigned magnitude of the current bin
//   mag_valid_in : mag_in carries a bin this cycle
//   mag_last_in  : current valid bin closes the frame
//   bin_index    : winning bin of the last completed frame (0 if below THRESHOLD)
//   peak_mag     : magnitude of the winning bin (0 if below THRESHOLD)
//   ready_out    : one-cycle pulse when bin_index/peak_mag update
//   frame_err    : sticky, set when a frame ran past 8192 bins
module peak_bin_finder #(
   parameter int MAG_WIDTH = 32,
   parameter int MIN_BIN   = 120,
   parameter int MAX_BIN   = 440,
   parameter int THRESHOLD = 1024
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic [MAG_WIDTH-1:0] mag_in,
   input  logic                 mag_valid_in,
   input  logic                 mag_last_in,
   output logic [12:0]          bin_index,
   output logic [MAG_WIDTH-1:0] peak_mag,
   output logic                 ready_out,
   output logic                 frame_err
);
   localparam logic [12:0]          MIN_B = 13'(MIN_BIN);
   localparam logic [12:0]          MAX_B = 13'(MAX_BIN);
   localparam logic [MAG_WIDTH-1:0] THR   = MAG_WIDTH'(THRESHOLD);
   typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;
   state_t                 state_q, state_d;
   logic [12:0]            cnt_q, cnt_d, max_bin_q, max_bin_d, idx, base_bin, bin_q;
   logic [MAG_WIDTH-1:0]   max_q, max_d, base_max, peak_q;
   logic                   accept, hit, done, ready_q, err_q, err_d;
   // In IDLE the incoming bin is bin 0 and compares against a cleared maximum,
   // so the first bin of a frame takes part in the search.
   always_comb begin
      accept    = mag_valid_in && state_q != REPORT;
      idx       = state_q == IDLE ? 13'd0 : cnt_q;
      base_max  = state_q == IDLE ? '0 : max_q;
      base_bin  = state_q == IDLE ? 13'd0 : max_bin_q;
      hit       = accept && idx >= MIN_B && idx <= MAX_B && mag_in > base_max;
      max_d     = hit ? mag_in : accept ? base_max : max_q;
      max_bin_d = hit ? idx : accept ? base_bin : max_bin_q;
      cnt_d     = accept ? idx + 13'd1 : cnt_q;
      done      = accept && (mag_last_in || idx == 13'h1fff);
      err_d     = err_q || (done && !mag_last_in);
      state_d   = state_q == REPORT ? IDLE : done ? REPORT : accept ? SCAN : state_q;
   end
   // Results are committed on the edge that accepts the last bin, using the
   // next-state maximum so the last bin is already included.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         max_q     <= '0;
         max_bin_q <= '0;
         bin_q     <= '0;
         peak_q    <= '0;
         ready_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         max_q     <= max_d;
         max_bin_q <= max_bin_d;
         ready_q   <= done;
         err_q     <= err_d;
         if (done) begin
            bin_q  <= max_d >= THR ? max_bin_d : 13'd0;
            peak_q <= max_d >= THR ? max_d : '0;
         end
      end
   end
   assign bin_index = bin_q;
   assign peak_mag  = peak_q;
   assign ready_out = ready_q;
   assign frame_err = err_q;
endmodule

// File: doc/peak_bin_finder.md
PEAK_BIN_FINDER -- requirements
Module: peak_bin_finder

Interface
REQ-001 SHALL have parameter MAG_WIDTH, default 32, meaning the width of the unsigned FFT magnitude sample.
REQ-002 SHALL have parameter MIN_BIN, default 120, meaning the lowest bin index eligible as a peak.
REQ-003 SHALL have parameter MAX_BIN, default 440, meaning the highest bin index eligible as a peak.
REQ-004 SHALL have parameter THRESHOLD, default 1024, meaning the minimum peak magnitude for a valid note.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with all flops in a single clock domain.
REQ-006 SHALL have port clk_in, input, 1 bit: the system clock, with all state updated on its rising edge.
REQ-007 SHALL have port rst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port mag_in, input, MAG_WIDTH bits: unsigned magnitude of the current bin.
REQ-009 SHALL have port mag_valid_in, input, 1 bit: mag_in carries a bin this cycle.
REQ-010 SHALL have port mag_last_in, input, 1 bit: the current valid bin is the last bin of the frame (qualified by mag_valid_in).
REQ-011 SHALL have port bin_index, output, 13 bits: the winning bin of the last completed frame, fed to the note lookup stage.
REQ-012 SHALL have port peak_mag, output, MAG_WIDTH bits: the magnitude of the winning bin.
REQ-013 SHALL have port ready_out, output, 1 bit: a one-cycle pulse when bin_index and peak_mag update.
REQ-014 SHALL have port frame_err, output, 1 bit: sticky flag set when a frame overran 8192 bins.

Function
REQ-015 SHALL implement the states IDLE, SCAN and REPORT.
- IDLE -> SCAN on the first mag_valid_in.
- SCAN -> REPORT on a valid bin with mag_last_in, or on a valid bin at internal count 8191.
- REPORT -> IDLE after exactly one cycle.
REQ-016 SHALL keep an internal 13-bit bin counter that is 0 for the first valid bin of each frame and increments by 1 per valid bin only.
- Cycles with mag_valid_in low SHALL not advance the counter or the comparison.
REQ-017 SHALL treat a bin as eligible only when MIN_BIN <= count <= MAX_BIN; ineligible bins SHALL never update the running maximum.
REQ-018 SHALL update the running maximum only when mag_in > running max (strict), so that on equal magnitudes the lowest bin wins.
REQ-019 SHALL clear the running maximum and its bin to 0 at frame start, and SHALL include the first bin of the frame in the comparison.
REQ-020 SHALL compare the last bin of a frame before the result is committed.
REQ-021 SHALL assert ready_out for exactly one cycle, in REPORT, one cycle after the last bin is accepted.
REQ-022 SHALL, in REPORT, load bin_index and peak_mag from the running maximum if max >= THRESHOLD, and otherwise load both with 0.
REQ-023 SHALL hold bin_index and peak_mag stable between REPORT cycles.
REQ-024 SHALL ignore a mag_valid_in that arrives in the REPORT cycle.
- The next frame starts from IDLE on the following valid bin.
- Upstream SHALL insert at least one idle cycle between frames.
REQ-025 SHALL, when count 8191 is reached without mag_last_in, end the frame, set frame_err, and report normally.
- Subsequent bins up to mag_last_in SHALL be treated as a new frame.
REQ-026 SHALL clear frame_err only by reset.
REQ-027 SHALL end a frame with a single bin when mag_valid_in and mag_last_in occur on the first bin.

Reset
REQ-028 SHALL, while rst_n_in is low, immediately force state to IDLE and clear all of the following to 0: counter, running maximum, bin_index, peak_mag, ready_out, frame_err.
REQ-029 SHALL discard a frame in progress when reset is asserted mid-frame, and SHALL not pulse ready_out for that frame.
REQ-030 SHALL begin operation on the first rising edge after rst_n_in deasserts.

Verification
REQ-031 SHALL verify single peak: 512-bin frame, all bins 10 except bin 200 = 5000 -> one ready_out pulse, bin_index=200, peak_mag=5000.
REQ-032 SHALL verify window and tie: bin 50 = 9000 (out of window), bins 150 and 300 = 3000 -> bin_index=150, peak_mag=3000.
REQ-033 SHALL verify below threshold: all bins 500 -> ready_out pulses, bin_index=0, peak_mag=0.
REQ-034 SHALL verify gapped stream: mag_valid_in toggled randomly, peak at bin 400 = 2000 -> bin_index=400, and the pulse comes one cycle after the last valid bin.
REQ-035 SHALL verify reset mid-frame: rst_n_in low at bin 250 of a frame with a peak at 180 -> no ready_out; outputs 0; the next full frame with a peak at 300 gives bin_index=300.
REQ-036 SHALL verify overrun: 8300 bins without mag_last_in -> frame_err=1 and ready_out pulses after bin 8191; frame_err stays 1 until reset.
